// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types, timing constants and ASCII-to-Morse encoder
//
// Purpose:
//   Types and helpers shared by the Morse keyer sources.
//   code_t  : {len[2:0], pat[4:0]}. The low len bits of pat hold the elements,
//             MSB-first, 1 = dash.
//   state_t : keyer sequencing states.
//   ascii_to_morse() : case-folding encoder. ' ' gives CODE_WORD_SPACE and any
//             other unsupported code gives CODE_INVALID.
// Ports: none (package).

package morse_pkg;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MARK,
    S_SPACE,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  // Both special codes use len = 0, which no printable character can produce.
  // The pattern bits tell the two codes apart.
  localparam code_t CODE_WORD_SPACE = '{len: 3'd0, pat: 5'b11111};
  localparam code_t CODE_INVALID    = '{len: 3'd0, pat: 5'b00000};

  localparam int DOT_UNITS      = 1;
  localparam int DASH_UNITS     = 3;
  localparam int SPACE_UNITS    = 1;
  localparam int CHAR_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS = 4;

  function automatic code_t ascii_to_morse(input logic [7:0] ch);
    logic [7:0] c;
    logic [3:0] d;
    code_t      code;
    c    = ch;
    code = CODE_INVALID;
    if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
    d = c[3:0];
    if (c == 8'h20) begin
      code = CODE_WORD_SPACE;
    end else if (c >= 8'h30 && c <= 8'h39) begin
      // Digits 0-5 are d leading dots followed by dashes.
      // Digits 6-9 are (d-5) leading dashes followed by dots.
      code.len = 3'd5;
      if (d <= 4'd5) code.pat = 5'b11111 >> d;
      else           code.pat = ~(5'b11111 >> (d - 4'd5));
    end else begin
      case (c)
        "A": code = '{3'd2, 5'b00001};
        "B": code = '{3'd4, 5'b01000};
        "C": code = '{3'd4, 5'b01010};
        "D": code = '{3'd3, 5'b00100};
        "E": code = '{3'd1, 5'b00000};
        "F": code = '{3'd4, 5'b00010};
        "G": code = '{3'd3, 5'b00110};
        "H": code = '{3'd4, 5'b00000};
        "I": code = '{3'd2, 5'b00000};
        "J": code = '{3'd4, 5'b00111};
        "K": code = '{3'd3, 5'b00101};
        "L": code = '{3'd4, 5'b00100};
        "M": code = '{3'd2, 5'b00011};
        "N": code = '{3'd2, 5'b00010};
        "O": code = '{3'd3, 5'b00111};
        "P": code = '{3'd4, 5'b00110};
        "Q": code = '{3'd4, 5'b01101};
        "R": code = '{3'd3, 5'b00010};
        "S": code = '{3'd3, 5'b00000};
        "T": code = '{3'd1, 5'b00001};
        "U": code = '{3'd3, 5'b00001};
        "V": code = '{3'd4, 5'b00001};
        "W": code = '{3'd3, 5'b00011};
        "X": code = '{3'd4, 5'b01001};
        "Y": code = '{3'd4, 5'b01011};
        "Z": code = '{3'd4, 5'b01100};
        default: code = CODE_INVALID;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/morse_fifo.sv
// rtl/morse_fifo.sv - synchronous FIFO with flush for the Morse keyer
//
// Purpose:
//   Single-clock queue with first-word fall-through reads. rd_data always shows
//   the head entry. A read and a write in the same cycle are both honoured.
//   flush empties the queue on the next edge and takes priority over both.
// Ports:
//   clk     in   1      clock
//   rst_n   in   1      asynchronous active-low reset
//   flush   in   1      synchronous clear
//   wr_data in   WIDTH  data to enqueue
//   wr_en   in   1      enqueue request (ignored when full)
//   rd_en   in   1      dequeue request (ignored when empty)
//   rd_data out  WIDTH  head entry
//   full    out  1      DEPTH entries held
//   empty   out  1      no entries held

module morse_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // The extra MSB on each pointer separates the full state from the empty state.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/morse_rgb_player.sv
// rtl/morse_rgb_player.sv - buffered Morse keyer driving an RGB LED
//
// Purpose:
//   Queues ASCII characters and keys them with standard Morse timing.
//   Green lights during a dot and blue during a dash. Red shows that the queue
//   is full.
//   Optional build macro MORSE_FARNSWORTH_EN: the inter-character and word gaps
//   are timed in GAP_UNIT_US units. Marks and intra-character spaces stay on
//   UNIT_US.
// Ports:
//   i_clk        in   1  system clock
//   i_rst_n      in   1  asynchronous active-low reset
//   i_char       in   8  ASCII character
//   i_char_valid in   1  character valid; transfer when valid && o_ready
//   o_ready      out  1  queue not full
//   i_abort      in   1  synchronous flush and stop
//   o_busy       out  1  queue non-empty or element/gap in progress
//   o_key        out  1  Morse key (1 = mark)
//   o_led_r      out  1  queue full
//   o_led_g      out  1  dot mark
//   o_led_b      out  1  dash mark

module morse_rgb_player
  import morse_pkg::*;
#(
  parameter int CLK_HZ      = 24000000,
  parameter int UNIT_US     = 60000,
  parameter int GAP_UNIT_US = 180000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_char,
  input  logic       i_char_valid,
  output logic       o_ready,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_key,
  output logic       o_led_r,
  output logic       o_led_g,
  output logic       o_led_b
);

  localparam int CYC_PER_US = CLK_HZ / 1000000;
  localparam int UNIT_CYC   = CYC_PER_US * UNIT_US;
  localparam int GAP_CYC    = CYC_PER_US * GAP_UNIT_US;
  // The prescaler is wide enough for either unit length in every build.
  localparam int MAX_CYC    = (GAP_CYC > UNIT_CYC) ? GAP_CYC : UNIT_CYC;
  localparam int CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYC - 1);
`ifdef MORSE_FARNSWORTH_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
`endif

  state_t           state;
  state_t           next_state;
  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  code_t            code;

  // The current element is always shreg[4]. The register shifts left as each
  // mark completes.
  logic [4:0]       shreg;
  logic [2:0]       elem_left;
  logic [CNT_W-1:0] pre_cnt;
  logic [2:0]       unit_cnt;
  logic [CNT_W-1:0] term_last;
  logic [2:0]       units;
  logic             timed;
  logic             elem_done;

  logic             key_q;
  logic             led_g_q;
  logic             led_b_q;
  logic             busy_q;

  morse_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .flush   (i_abort),
    .wr_data (i_char),
    .wr_en   (i_char_valid),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign code = ascii_to_morse(fifo_data);

  // Length of the current element in units, and the prescaler terminal count
  // for the current state.
  always_comb begin
    units     = 3'(SPACE_UNITS);
    term_last = UNIT_LAST;
    timed     = 1'b0;
    case (state)
      S_MARK: begin
        units = shreg[4] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
        timed = 1'b1;
      end
      S_SPACE: begin
        units = 3'(SPACE_UNITS);
        timed = 1'b1;
      end
      S_CHAR_GAP: begin
        units = 3'(CHAR_GAP_UNITS);
        timed = 1'b1;
`ifdef MORSE_FARNSWORTH_EN
        term_last = GAP_LAST;
`endif
      end
      S_WORD_GAP: begin
        units = 3'(WORD_GAP_UNITS);
        timed = 1'b1;
`ifdef MORSE_FARNSWORTH_EN
        term_last = GAP_LAST;
`endif
      end
      default: ;
    endcase
  end

  assign elem_done = timed && (pre_cnt == term_last) && (unit_cnt == units - 3'd1);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    if (i_abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (!fifo_empty) next_state = S_LOAD;
        S_LOAD: begin
          if (fifo_empty) begin
            next_state = S_IDLE;
          end else begin
            pop = 1'b1;
            // Unsupported characters are dropped here and the next entry is
            // loaded on the following cycle.
            if (code == CODE_WORD_SPACE)   next_state = S_WORD_GAP;
            else if (code.len == 3'd0)     next_state = S_LOAD;
            else                           next_state = S_MARK;
          end
        end
        S_MARK: begin
          if (elem_done) next_state = (elem_left == 3'd0) ? S_CHAR_GAP : S_SPACE;
        end
        S_SPACE: if (elem_done) next_state = S_MARK;
        S_CHAR_GAP, S_WORD_GAP: begin
          if (elem_done) next_state = fifo_empty ? S_IDLE : S_LOAD;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      elem_left <= '0;
      pre_cnt   <= '0;
      unit_cnt  <= '0;
    end else begin
      state <= next_state;

      // The prescaler restarts on every state change, so each element or gap
      // lasts exactly units * (term_last + 1) cycles.
      if (state != next_state || !timed) begin
        pre_cnt  <= '0;
        unit_cnt <= '0;
      end else if (pre_cnt == term_last) begin
        pre_cnt  <= '0;
        unit_cnt <= unit_cnt + 3'd1;
      end else begin
        pre_cnt  <= pre_cnt + CNT_W'(1);
      end

      if (state == S_LOAD && pop) begin
        shreg     <= code.pat << (3'd5 - code.len);
        elem_left <= code.len - 3'd1;
      end else if (state == S_MARK && next_state == S_SPACE) begin
        shreg     <= shreg << 1;
        elem_left <= elem_left - 3'd1;
      end
    end
  end

  // The key, LED and busy outputs are registered one cycle behind the state.
  // An abort clears them on the same edge that forces the state to IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      key_q   <= 1'b0;
      led_g_q <= 1'b0;
      led_b_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      key_q   <= !i_abort && (state == S_MARK);
      led_g_q <= !i_abort && (state == S_MARK) && !shreg[4];
      led_b_q <= !i_abort && (state == S_MARK) && shreg[4];
      busy_q  <= !i_abort && ((state != S_IDLE) || !fifo_empty);
    end
  end

  assign o_key   = key_q;
  assign o_led_g = led_g_q;
  assign o_led_b = led_b_q;
  assign o_busy  = busy_q;
  assign o_ready = !fifo_full;
  assign o_led_r = fifo_full;

endmodule

// File: tb/tb_morse_rgb_player.sv
// tb/tb_morse_rgb_player.sv - directed self-checking bench for morse_rgb_player

module tb_morse_rgb_player;

  localparam int UNIT = 10;
`ifdef MORSE_FARNSWORTH_EN
  localparam int GAP = 20;
`else
  localparam int GAP = 10;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_char = 8'h00;
  logic       i_char_valid = 1'b0;
  logic       i_abort = 1'b0;
  logic       o_ready;
  logic       o_busy;
  logic       o_key;
  logic       o_led_r;
  logic       o_led_g;
  logic       o_led_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mark_len[$];
  int run = 0;

  morse_rgb_player #(
    .CLK_HZ      (1000000),
    .UNIT_US     (10),
    .GAP_UNIT_US (20),
    .FIFO_DEPTH  (8)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_char       (i_char),
    .i_char_valid (i_char_valid),
    .o_ready      (o_ready),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_key        (o_key),
    .o_led_r      (o_led_r),
    .o_led_g      (o_led_g),
    .o_led_b      (o_led_b)
  );

  always #5 i_clk = ~i_clk;

  // cyc holds the index of the most recent rising edge.
  always @(posedge i_clk) cyc <= cyc + 1;

  // Records the length of every completed mark, in cycles.
  always @(negedge i_clk) begin
    if (o_key === 1'b1) begin
      run = run + 1;
    end else if (run != 0) begin
      mark_len.push_back(run);
      run = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] c, output int acc);
    i_char = c;
    i_char_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_char_valid = 1'b0;
    acc = cyc;
  endtask

  // Returns the edge index at which o_key reached the level, or -1 on timeout.
  task automatic wait_key(input logic level, input int budget, output int idx);
    idx = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge i_clk);
      if (o_key === level) begin
        idx = cyc;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output int idx);
    idx = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge i_clk);
      if (o_busy === 1'b0) begin
        idx = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    vectors++; if (o_key !== 1'b0)   begin miscompares++; $display("FAIL reset_key: got %b want 0", o_key); end
    vectors++; if (o_busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    vectors++; if ({o_led_r, o_led_g, o_led_b} !== 3'b000) begin
      miscompares++; $display("FAIL reset_leds: got %b want 000", {o_led_r, o_led_g, o_led_b});
    end
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    vectors++; if ({o_key, o_busy} !== 2'b00) begin
      miscompares++; $display("FAIL post_reset_idle: got key,busy=%b want 00", {o_key, o_busy});
    end
  endtask

  task automatic test_dot();
    int acc, r, f, b;
    push("E", acc);
    wait_key(1'b1, 20, r);
    vectors++; if (r - acc !== 3) begin miscompares++; $display("FAIL dot_latency: got %0d want 3", r - acc); end
    vectors++; if ({o_led_g, o_led_b} !== 2'b10) begin
      miscompares++; $display("FAIL dot_leds: got gb=%b want 10", {o_led_g, o_led_b});
    end
    wait_key(1'b0, 50, f);
    vectors++; if (f - r !== UNIT) begin miscompares++; $display("FAIL dot_len: got %0d want %0d", f - r, UNIT); end
    wait_idle(200, b);
    vectors++; if (b - f !== 3 * GAP) begin
      miscompares++; $display("FAIL dot_busy_fall: got %0d want %0d", b - f, 3 * GAP);
    end
  endtask

  task automatic test_dash();
    int acc, r, f, b;
    push("t", acc);
    wait_key(1'b1, 20, r);
    vectors++; if ({o_led_g, o_led_b} !== 2'b01) begin
      miscompares++; $display("FAIL dash_leds_start: got gb=%b want 01", {o_led_g, o_led_b});
    end
    repeat (15) @(negedge i_clk);
    vectors++; if ({o_key, o_led_g, o_led_b} !== 3'b101) begin
      miscompares++; $display("FAIL dash_leds_mid: got key,g,b=%b want 101", {o_key, o_led_g, o_led_b});
    end
    wait_key(1'b0, 50, f);
    vectors++; if (f - r !== 3 * UNIT) begin miscompares++; $display("FAIL dash_len: got %0d want %0d", f - r, 3 * UNIT); end
    wait_idle(200, b);
  endtask

  task automatic test_letter_a();
    int acc, r1, f1, r2, f2, b;
    push("A", acc);
    wait_key(1'b1, 20, r1);
    wait_key(1'b0, 50, f1);
    wait_key(1'b1, 50, r2);
    vectors++; if (o_led_b !== 1'b1) begin miscompares++; $display("FAIL a_dash_led: got %b want 1", o_led_b); end
    wait_key(1'b0, 50, f2);
    wait_idle(200, b);
    vectors++; if (f1 - r1 !== UNIT)     begin miscompares++; $display("FAIL a_dot_len: got %0d want %0d", f1 - r1, UNIT); end
    vectors++; if (r2 - f1 !== UNIT)     begin miscompares++; $display("FAIL a_space_len: got %0d want %0d", r2 - f1, UNIT); end
    vectors++; if (f2 - r2 !== 3 * UNIT) begin miscompares++; $display("FAIL a_dash_len: got %0d want %0d", f2 - r2, 3 * UNIT); end
    vectors++; if (b - f2 !== 3 * GAP)   begin miscompares++; $display("FAIL a_char_gap: got %0d want %0d", b - f2, 3 * GAP); end
  endtask

  // Key-off time between characters is the gap plus one LOAD cycle per
  // character popped.
  task automatic test_back_to_back();
    int acc, r1, f1, r2, f2, b;
    push("E", acc);
    push("E", acc);
    wait_key(1'b1, 20, r1);
    wait_key(1'b0, 50, f1);
    wait_key(1'b1, 200, r2);
    wait_key(1'b0, 50, f2);
    vectors++; if (r2 - f1 !== 3 * GAP + 1) begin
      miscompares++; $display("FAIL ee_gap: got %0d want %0d", r2 - f1, 3 * GAP + 1);
    end
    vectors++; if (f2 - r2 !== UNIT) begin miscompares++; $display("FAIL ee_mark2_len: got %0d want %0d", f2 - r2, UNIT); end
    wait_idle(200, b);
  endtask

  task automatic test_word_space();
    int acc, r1, f1, r2, b;
    push("E", acc);
    push(" ", acc);
    push("E", acc);
    wait_key(1'b1, 20, r1);
    wait_key(1'b0, 50, f1);
    wait_key(1'b1, 400, r2);
    vectors++; if (r2 - f1 !== 7 * GAP + 2) begin
      miscompares++; $display("FAIL word_gap: got %0d want %0d", r2 - f1, 7 * GAP + 2);
    end
    wait_idle(400, b);
    vectors++; if (b < 0) begin miscompares++; $display("FAIL word_idle: got timeout want idle"); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] seq [9] = '{"E", "T", "T", "E", "E", "T", "E", "T", "E"};
    int acc, b, want;
    mark_len.delete();
    for (int i = 0; i < 9; i++) push(seq[i], acc);
    @(negedge i_clk);
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL fifo_ready_full: got %b want 0", o_ready); end
    vectors++; if (o_led_r !== 1'b1) begin miscompares++; $display("FAIL fifo_led_r: got %b want 1", o_led_r); end
    wait_idle(2000, b);
    vectors++; if (mark_len.size() !== 9) begin
      miscompares++; $display("FAIL fifo_mark_count: got %0d want 9", mark_len.size());
    end
    for (int i = 0; i < 9; i++) begin
      want = (seq[i] == "T") ? 3 * UNIT : UNIT;
      vectors++;
      if (i >= mark_len.size()) begin
        miscompares++; $display("FAIL fifo_mark%0d: got none want %0d", i, want);
      end else if (mark_len[i] !== want) begin
        miscompares++; $display("FAIL fifo_mark%0d: got %0d want %0d", i, mark_len[i], want);
      end
    end
    vectors++; if (o_led_r !== 1'b0) begin miscompares++; $display("FAIL fifo_led_r_drained: got %b want 0", o_led_r); end
  endtask

  task automatic test_invalid_and_abort();
    int a0, a1, r, b;
    mark_len.delete();
    push("#", a0);
    push("E", a1);
    wait_key(1'b1, 20, r);
    vectors++; if (r - a1 !== 3) begin miscompares++; $display("FAIL drop_latency: got %0d want 3", r - a1); end
    wait_idle(200, b);
    vectors++; if (mark_len.size() !== 1) begin
      miscompares++; $display("FAIL drop_marks: got %0d want 1", mark_len.size());
    end
    push("T", a0);
    wait_key(1'b1, 20, r);
    repeat (10) @(negedge i_clk);
    i_abort = 1'b1;
    i_char = "E";
    i_char_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_abort = 1'b0;
    i_char_valid = 1'b0;
    @(negedge i_clk);
    vectors++; if ({o_key, o_led_b} !== 2'b00) begin
      miscompares++; $display("FAIL abort_key: got key,b=%b want 00", {o_key, o_led_b});
    end
    vectors++; if (o_busy !== 1'b0)  begin miscompares++; $display("FAIL abort_busy: got %b want 0", o_busy); end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b want 1", o_ready); end
    wait_key(1'b1, 60, r);
    vectors++; if (r !== -1) begin miscompares++; $display("FAIL abort_push_dropped: got key at %0d want none", r); end
  endtask

  task automatic test_reset_mid_char();
    int acc, r;
    push("T", acc);
    wait_key(1'b1, 20, r);
    repeat (5) @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    vectors++; if ({o_key, o_led_b, o_busy} !== 3'b000) begin
      miscompares++; $display("FAIL midreset_outputs: got key,b,busy=%b want 000", {o_key, o_led_b, o_busy});
    end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready: got %b want 1", o_ready); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_key(1'b1, 60, r);
    vectors++; if (r !== -1) begin miscompares++; $display("FAIL midreset_resume: got key at %0d want none", r); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_dot();
    test_dash();
    test_letter_a();
    test_back_to_back();
    test_word_space();
    test_fifo_full();
    test_invalid_and_abort();
    test_reset_mid_char();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
